multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder, and its ALUop output feeds that decoder together with the instruction Func field. It sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, j and addi. Memory accesses stall on a ready handshake, and completed instructions are counted.

---
 rtl/multicycle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences IF/ID/EX/MEM/WB for R-type, lw, sw, beq, j and addi, stalls on
// mem_ready in IF, MR and MW, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_TRAP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUop,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MA   = 4'd2,
    S_MR   = 4'd3,
    S_MWB  = 4'd4,
    S_MW   = 4'd5,
    S_EX   = 4'd6,
    S_RWB  = 4'd7,
    S_BR   = 4'd8,
    S_JP   = 4'd9,
    S_AI   = 4'd10,
    S_AIWB = 4'd11,
    S_HALT = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  state_t     state_q, state_n;
  logic [5:0] op_q;
  logic       retire;

  // State register, opcode capture in ID, and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IF;
      op_q       <= '0;
      inst_count <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == S_ID) op_q <= op;
      if (retire) inst_count <= inst_count + CNT_W'(1);
    end
  end

  // Next-state and Moore/mem_ready-qualified output decode; reset gates everything
  always_comb begin
    state_n     = state_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUop       = 2'b00;
    illegal_op  = 1'b0;
    state       = state_q;

    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_n = S_ID;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_R:          state_n = S_EX;
          OP_LW, OP_SW:  state_n = S_MA;
          OP_BEQ:        state_n = S_BR;
          OP_J:          state_n = S_JP;
          OP_ADDI:       state_n = S_AI;
          default: begin
            if (ILLEGAL_TRAP) begin
              state_n = S_HALT;
            end else begin
              state_n    = S_IF;
              illegal_op = 1'b1;
            end
          end
        endcase
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_n = (op_q == OP_SW) ? S_MW : S_MR;
      end
      S_MR: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) state_n = S_MWB;
      end
      S_MWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_n  = S_IF;
        retire   = 1'b1;
      end
      S_MW: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          state_n = S_IF;
          retire  = 1'b1;
        end
      end
      S_EX: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        state_n = S_RWB;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_n  = S_IF;
        retire   = 1'b1;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_n     = S_IF;
        retire      = 1'b1;
      end
      S_JP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_n  = S_IF;
        retire   = 1'b1;
      end
      S_AI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_n = S_AIWB;
      end
      S_AIWB: begin
        RegWrite = 1'b1;
        state_n  = S_IF;
        retire   = 1'b1;
      end
      S_HALT: begin
        illegal_op = 1'b1;
      end
      default: state_n = S_IF;
    endcase

    // Reset aborts the current instruction immediately: no requests, no count
    if (rst) begin
      retire      = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      ALUop       = 2'b00;
      illegal_op  = 1'b0;
      state       = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instruction
// streams checked against a per-instruction state-sequence model.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance under main test (narrow counter so wraparound is reachable)
  logic       rst, mem_ready;
  logic [5:0] op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUop;
  logic [3:0] state;
  logic [3:0] inst_count;

  multicycle_ctrl #(.CNT_W(4), .ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .state(state), .illegal_op(illegal_op),
    .inst_count(inst_count)
  );

  // Trapping instance
  logic        rst_t = 1'b1, mem_ready_t = 1'b0;
  logic [5:0]  op_t = '0;
  logic        PCWrite_t, PCWriteCond_t, IorD_t, MemRead_t, MemWrite_t, IRWrite_t;
  logic        MemtoReg_t, RegDst_t, RegWrite_t, ALUSrcA_t, illegal_op_t;
  logic [1:0]  ALUSrcB_t, PCSource_t, ALUop_t;
  logic [3:0]  state_t;
  logic [31:0] inst_count_t;

  multicycle_ctrl #(.CNT_W(32), .ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .rst(rst_t), .op(op_t), .mem_ready(mem_ready_t),
    .PCWrite(PCWrite_t), .PCWriteCond(PCWriteCond_t), .IorD(IorD_t),
    .MemRead(MemRead_t), .MemWrite(MemWrite_t), .IRWrite(IRWrite_t),
    .MemtoReg(MemtoReg_t), .RegDst(RegDst_t), .RegWrite(RegWrite_t),
    .ALUSrcA(ALUSrcA_t), .ALUSrcB(ALUSrcB_t), .PCSource(PCSource_t),
    .ALUop(ALUop_t), .state(state_t), .illegal_op(illegal_op_t),
    .inst_count(inst_count_t)
  );

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, pcsrc, aluop;
    logic       ill;
  } outs_t;

  typedef struct { int st; bit rdy; } step_t;

  int ncmp  = 0;
  int nfail = 0;
  int cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic outs_t obs();
    return '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop, illegal_op};
  endfunction

  // Control-word table written straight from the per-state output list
  function automatic outs_t exp_outs(input int st, input bit r, input bit ill);
    outs_t o = '0;
    case (st)
      0:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = r; o.pcw = r; end
      1:  begin o.srcb = 2'b11; o.ill = ill; end
      2:  begin o.srca = 1; o.srcb = 2'b10; end
      3:  begin o.iord = 1; o.mrd = 1; end
      4:  begin o.m2r = 1; o.rwr = 1; end
      5:  begin o.iord = 1; o.mwr = 1; end
      6:  begin o.srca = 1; o.aluop = 2'b10; end
      7:  begin o.rdst = 1; o.rwr = 1; end
      8:  begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01; end
      9:  begin o.pcw = 1; o.pcsrc = 2'b10; end
      10: begin o.srca = 1; o.srcb = 2'b10; end
      11: begin o.rwr = 1; end
      12: begin o.ill = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Runs one instruction: builds the expected (state, mem_ready) trace from
  // the instruction class and wait counts, drives it, checks every cycle.
  task automatic run_inst(input logic [5:0] opv, input int w_if, input int w_mem);
    step_t seq[$];
    bit    legal = 1'b1;
    seq = {};
    for (int i = 0; i < w_if; i++) seq.push_back('{0, 1'b0});
    seq.push_back('{0, 1'b1});
    seq.push_back('{1, 1'($urandom)});
    case (opv)
      6'h00: begin seq.push_back('{6, 1'($urandom)}); seq.push_back('{7, 1'($urandom)}); end
      6'h23: begin
        seq.push_back('{2, 1'($urandom)});
        for (int i = 0; i < w_mem; i++) seq.push_back('{3, 1'b0});
        seq.push_back('{3, 1'b1});
        seq.push_back('{4, 1'($urandom)});
      end
      6'h2B: begin
        seq.push_back('{2, 1'($urandom)});
        for (int i = 0; i < w_mem; i++) seq.push_back('{5, 1'b0});
        seq.push_back('{5, 1'b1});
      end
      6'h04: seq.push_back('{8, 1'($urandom)});
      6'h02: seq.push_back('{9, 1'($urandom)});
      6'h08: begin seq.push_back('{10, 1'($urandom)}); seq.push_back('{11, 1'($urandom)}); end
      default: legal = 1'b0;
    endcase
    foreach (seq[i]) begin
      mem_ready = seq[i].rdy;
      op = (seq[i].st == 1) ? opv : 6'($urandom);
      @(negedge clk);
      check("state", 32'(state), 32'(seq[i].st));
      check("outs", 32'(obs()), 32'(exp_outs(seq[i].st, seq[i].rdy, !legal)));
      check("cnt_hold", 32'(inst_count), 32'(cnt % 16));
      @(posedge clk); #1;
    end
    if (legal) cnt++;
    check("cnt_after", 32'(inst_count), 32'(cnt % 16));
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops[0] = 6'h00; legal_ops[1] = 6'h23; legal_ops[2] = 6'h2B;
    legal_ops[3] = 6'h04; legal_ops[4] = 6'h02; legal_ops[5] = 6'h08;

    // Reset: outputs gated, state 0, counter cleared
    rst = 1'b1; mem_ready = 1'b1; op = 6'h00;
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(obs()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cnt = 0;
    check("rst_cnt", 32'(inst_count), 32'd0);

    // Directed instructions
    run_inst(6'h00, 0, 0);  // R-type
    run_inst(6'h23, 0, 2);  // lw with two MR stalls
    run_inst(6'h2B, 0, 0);  // sw
    run_inst(6'h04, 0, 0);  // beq
    run_inst(6'h02, 0, 0);  // j
    run_inst(6'h08, 3, 0);  // addi after three IF stalls
    run_inst(6'h3F, 0, 0);  // illegal, not counted
    run_inst(6'h2B, 1, 2);  // sw with stalls

    // Random stream, long enough to wrap the 4-bit counter
    for (int n = 0; n < 40; n++) begin
      logic [5:0] o;
      o = ($urandom % 5 == 0) ? 6'($urandom) : legal_ops[$urandom % 6];
      run_inst(o, int'($urandom % 3), int'($urandom % 3));
    end

    // Reset while stalled in MW: write dropped, counter cleared
    mem_ready = 1'b1; op = 6'h00;
    @(posedge clk); #1;            // IF -> ID
    op = 6'h2B;
    @(posedge clk); #1;            // ID -> MA
    op = 6'h00;
    @(posedge clk); #1;            // MA -> MW
    mem_ready = 1'b0;
    @(negedge clk);
    check("mw_state", 32'(state), 32'd5);
    check("mw_write", 32'(MemWrite), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mwrst_write", 32'(MemWrite), 32'd0);
    check("mwrst_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cnt = 0;
    check("mwrst_cnt", 32'(inst_count), 32'd0);
    @(negedge clk);
    check("mwrst_next", 32'(state), 32'd0);

    // Trapping instance: unknown opcode parks in HALT until reset
    @(posedge clk); #1;
    rst_t = 1'b0; mem_ready_t = 1'b1;
    @(negedge clk);
    check("trap_if", 32'(state_t), 32'd0);
    @(posedge clk); #1;
    op_t = 6'h3F;
    @(negedge clk);
    check("trap_id", 32'(state_t), 32'd1);
    check("trap_id_ill", 32'(illegal_op_t), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      op_t = 6'($urandom); mem_ready_t = 1'($urandom);
      @(negedge clk);
      check("halt_state", 32'(state_t), 32'd12);
      check("halt_ill", 32'(illegal_op_t), 32'd1);
      check("halt_outs", 32'({PCWrite_t, PCWriteCond_t, IorD_t, MemRead_t, MemWrite_t,
                              IRWrite_t, RegWrite_t}), 32'd0);
      check("halt_cnt", inst_count_t, 32'd0);
      @(posedge clk); #1;
    end
    rst_t = 1'b1;
    @(negedge clk);
    check("halt_rst_ill", 32'(illegal_op_t), 32'd0);
    @(posedge clk); #1;
    rst_t = 1'b0;
    @(negedge clk);
    check("halt_rst_state", 32'(state_t), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
